// File: rtl/encrypt_v2_pkg.sv
// Shared types and cipher primitives (round, key schedule, key addition) for encrypt_v2.
// 64-bit block, 80-bit key substitution-permutation cipher.
package encrypt_v2_pkg;

  localparam int unsigned N_B = 64;
  localparam int unsigned N_K = 80;
  localparam int unsigned N_R = 31;

  typedef logic [N_B-1:0] blk_t;
  typedef logic [N_K-1:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    key_t key;
    blk_t blk;
  } req_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    y = 4'h0;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic blk_t sbox_layer(input blk_t s);
    blk_t r;
    r = '0;
    for (int n = 0; n < int'(N_B / 4); n++) begin
      r[4*n +: 4] = sbox4(s[4*n +: 4]);
    end
    return r;
  endfunction

  // Bit i moves to 16*(i mod 4) + i/4.
  function automatic blk_t p_layer(input blk_t s);
    blk_t r;
    r = '0;
    for (int i = 0; i < int'(N_B); i++) begin
      r[16*(i%4) + i/4] = s[i];
    end
    return r;
  endfunction

  function automatic blk_t round_fn(input blk_t b, input key_t k);
    return p_layer(sbox_layer(b ^ k[N_K-1 -: N_B]));
  endfunction

  function automatic key_t key_schedule(input key_t k, input logic [4:0] rc);
    key_t r;
    r = {k[18:0], k[N_K-1:19]};
    r[N_K-1 -: 4] = sbox4(r[N_K-1 -: 4]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  function automatic blk_t key_addition(input blk_t b, input key_t k);
    return b ^ k[N_K-1 -: N_B];
  endfunction

endpackage

// File: rtl/encrypt_v2_round_step.sv
// One gated cipher stage: round then key schedule when r <= N_R, otherwise pass-through.
module encrypt_v2_round_step
  import encrypt_v2_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic [N_B-1:0]   blk_i,
  input  logic [N_K-1:0]   key_i,
  input  logic [CNT_W-1:0] r_i,
  output logic [N_B-1:0]   blk_o,
  output logic [N_K-1:0]   key_o
);

  logic en;

  assign en    = (r_i <= CNT_W'(N_R));
  // Round consumes the pre-schedule key of the same index.
  assign blk_o = en ? round_fn(blk_i, key_i) : blk_i;
  assign key_o = en ? key_schedule(key_i, r_i[4:0]) : key_i;

endmodule

// File: rtl/encrypt_v2.sv
// Iterative block cipher: UNROLL rounds per clock, valid/ready on request and result sides.
// c and out_valid are registered; in_ready is a decode of state and out_ready.
module encrypt_v2
  import encrypt_v2_pkg::*;
#(
  parameter int unsigned UNROLL = 1,
  parameter int unsigned RC_W   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_K-1:0] k,
  input  logic [N_B-1:0] m,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_B-1:0] c,
  output logic           busy
);

  // Round-index register sized so rnd_q + UNROLL never wraps.
  localparam int unsigned CNT_MIN = $clog2(N_R + UNROLL + 1);
  localparam int unsigned CNT_W   = (RC_W > CNT_MIN) ? RC_W : CNT_MIN;

  if (UNROLL < 1 || UNROLL > N_R) begin : g_bad_unroll
    $error("encrypt_v2: UNROLL must be within 1..N_R");
  end
  if ((1 << CNT_W) <= (N_R + UNROLL)) begin : g_bad_cnt
    $error("encrypt_v2: round index width too small");
  end
  if ((1 << RC_W) <= N_R) begin : g_bad_rcw
    $error("encrypt_v2: RC_W cannot index N_R rounds");
  end

  state_e           state_q, state_d;
  blk_t             blk_q, blk_d;
  key_t             key_q, key_d;
  blk_t             c_q, c_d;
  logic             ov_q, ov_d;
  logic [CNT_W-1:0] rnd_q, rnd_d;

  req_t req;
  logic accept;
  logic last;

  blk_t blk_ch [UNROLL+1];
  key_t key_ch [UNROLL+1];

  assign req      = '{key: k, blk: m};
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (rnd_q + CNT_W'(UNROLL)) > CNT_W'(N_R);

  assign blk_ch[0] = blk_q;
  assign key_ch[0] = key_q;

  for (genvar j = 0; j < int'(UNROLL); j++) begin : g_stage
    encrypt_v2_round_step #(
      .CNT_W(CNT_W)
    ) u_step (
      .blk_i(blk_ch[j]),
      .key_i(key_ch[j]),
      .r_i  (rnd_q + CNT_W'(j)),
      .blk_o(blk_ch[j+1]),
      .key_o(key_ch[j+1])
    );
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    key_d   = key_q;
    c_d     = c_q;
    ov_d    = ov_q;
    rnd_d   = rnd_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          blk_d   = req.blk;
          key_d   = req.key;
          rnd_d   = CNT_W'(1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        blk_d = blk_ch[UNROLL];
        key_d = key_ch[UNROLL];
        rnd_d = rnd_q + CNT_W'(UNROLL);
        if (last) begin
          c_d     = key_addition(blk_ch[UNROLL], key_ch[UNROLL]);
          ov_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ST_IDLE;
          if (in_valid) begin
            blk_d   = req.blk;
            key_d   = req.key;
            rnd_d   = CNT_W'(1);
            state_d = ST_BUSY;
          end
        end
      end
      default: begin
        ov_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      key_q   <= '0;
      c_q     <= '0;
      ov_q    <= 1'b0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      key_q   <= key_d;
      c_q     <= c_d;
      ov_q    <= ov_d;
      rnd_q   <= rnd_d;
    end
  end

  assign c         = c_q;
  assign out_valid = ov_q;
  assign busy      = (state_q == ST_BUSY);

endmodule

// File: tb/tb_encrypt_v2.sv
// Scoreboard bench for encrypt_v2: three instances (UNROLL = 1, 4, 31) against a behavioural cipher model.
module tb_encrypt_v2;

  localparam int NL = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_s  [NL];
  logic        in_ready_s  [NL];
  logic [79:0] k_s         [NL];
  logic [63:0] m_s         [NL];
  logic        out_valid_s [NL];
  logic        out_ready_s [NL];
  logic [63:0] c_s         [NL];
  logic        busy_s      [NL];

  int          sink_mode [NL];
  logic        rnd_rdy   [NL] = '{default: 1'b1};

  logic [63:0] exp_q [NL][$];
  int          acc_q [NL][$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [3:0] sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int unsigned U = (g == 0) ? 1 : (g == 1) ? 4 : 31;
    encrypt_v2 #(.UNROLL(U)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_s[g]),
      .in_ready (in_ready_s[g]),
      .k        (k_s[g]),
      .m        (m_s[g]),
      .out_valid(out_valid_s[g]),
      .out_ready(out_ready_s[g]),
      .c        (c_s[g]),
      .busy     (busy_s[g])
    );
    assign out_ready_s[g] = (sink_mode[g] == 0) ? 1'b1 :
                            (sink_mode[g] == 2) ? 1'b0 : rnd_rdy[g];
  end

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NL; i++) rnd_rdy[i] <= 1'($urandom_range(0, 1));
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 31 : (i == 1) ? 8 : 1;
  endfunction

  // Cipher written straight from its definition: 31 rounds, then final whitening.
  function automatic logic [63:0] ref_enc(input logic [79:0] key_in, input logic [63:0] pt);
    logic [79:0] key;
    logic [63:0] st;
    logic [63:0] nx;
    key = key_in;
    st  = pt;
    for (int r = 1; r <= 31; r++) begin
      st = st ^ key[79:16];
      for (int n = 0; n < 16; n++) st[4*n +: 4] = sb[st[4*n +: 4]];
      nx = '0;
      for (int b = 0; b < 64; b++) nx[(b == 63) ? 63 : (b * 16) % 63] = st[b];
      st  = nx;
      key = (key << 61) | (key >> 19);
      key[79:76] = sb[key[79:76]];
      key[19:15] = key[19:15] ^ 5'(r);
    end
    return st ^ key[79:16];
  endfunction

  task automatic check_w(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_n(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: latency on each rising out_valid, stability while held, value on handshake.
  logic        prev_ov [NL] = '{default: 1'b0};
  logic [63:0] hold_c  [NL];

  always @(negedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (!rst_n) begin
        prev_ov[i] = 1'b0;
      end else begin
        if (out_valid_s[i] && !prev_ov[i]) begin
          hold_c[i] = c_s[i];
          if (acc_q[i].size() == 0) check_b($sformatf("spurious_valid_l%0d", i), 1'b1, 1'b0);
          else check_n($sformatf("latency_l%0d", i), cyc - acc_q[i].pop_front(), lat_of(i));
        end else if (out_valid_s[i]) begin
          check_w($sformatf("c_stable_l%0d", i), c_s[i], hold_c[i]);
        end
        if (out_valid_s[i] && out_ready_s[i]) begin
          if (exp_q[i].size() == 0) check_b($sformatf("unexpected_out_l%0d", i), 1'b1, 1'b0);
          else check_w($sformatf("c_l%0d", i), c_s[i], exp_q[i].pop_front());
        end
        prev_ov[i] = out_valid_s[i];
      end
    end
  end

  task automatic send(input int ln, input logic [79:0] kk, input logic [63:0] mm,
                      input logic [63:0] ex);
    int w;
    w = 0;
    @(posedge clk); #1;
    in_valid_s[ln] = 1'b1;
    k_s[ln] = kk;
    m_s[ln] = mm;
    @(negedge clk);
    while (!in_ready_s[ln] && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready_s[ln]) begin
      check_b($sformatf("accept_timeout_l%0d", ln), 1'b0, 1'b1);
    end else begin
      exp_q[ln].push_back(ex);
      acc_q[ln].push_back(cyc + 1);
    end
    @(posedge clk); #1;
    in_valid_s[ln] = 1'b0;
  endtask

  task automatic wait_done(input int ln);
    int w;
    w = 0;
    while (exp_q[ln].size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check_n($sformatf("drain_l%0d", ln), exp_q[ln].size(), 0);
  endtask

  initial begin
    logic [79:0] kk;
    logic [63:0] mm;
    int w;
    for (int i = 0; i < NL; i++) begin
      in_valid_s[i] = 1'b0;
      k_s[i] = '0;
      m_s[i] = '0;
      sink_mode[i] = 0;
    end

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) begin
      check_b($sformatf("rst_out_valid_l%0d", i), out_valid_s[i], 1'b0);
      check_b($sformatf("rst_busy_l%0d", i), busy_s[i], 1'b0);
      check_w($sformatf("rst_c_l%0d", i), c_s[i], 64'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NL; i++) check_b($sformatf("rst_in_ready_l%0d", i), in_ready_s[i], 1'b1);

    // Vector 1 on UNROLL=1, with in_valid pushed during BUSY that must be ignored
    send(0, 80'h0, 64'h0, 64'h5579C1387B228445);
    @(negedge clk);
    check_b("busy_l0", busy_s[0], 1'b1);
    check_b("in_ready_busy_l0", in_ready_s[0], 1'b0);
    @(posedge clk); #1;
    in_valid_s[0] = 1'b1;
    k_s[0] = 80'h1234;
    m_s[0] = 64'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    wait_done(0);

    // Vectors 2..4: remainder bypass (UNROLL=4) and single-cycle (UNROLL=31)
    send(1, {80{1'b1}}, 64'h0, 64'hE72C46C0F5945049);
    send(2, 80'h0, {64{1'b1}}, 64'hA112FFC72F68417B);
    send(2, {80{1'b1}}, {64{1'b1}}, 64'h3333DCD3213210D2);
    for (int i = 0; i < NL; i++) wait_done(i);

    // Backpressure stall then back-to-back accept on UNROLL=4
    sink_mode[1] = 2;
    kk = {16'($urandom), $urandom, $urandom};
    mm = {$urandom, $urandom};
    send(1, kk, mm, ref_enc(kk, mm));
    w = 0;
    while (!out_valid_s[1] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_b("stall_valid_l1", out_valid_s[1], 1'b1);
    repeat (10) @(negedge clk);
    kk = {16'($urandom), $urandom, $urandom};
    mm = {$urandom, $urandom};
    @(posedge clk); #1;
    in_valid_s[1] = 1'b1;
    k_s[1] = kk;
    m_s[1] = mm;
    sink_mode[1] = 0;
    @(negedge clk);
    check_b("b2b_in_ready_l1", in_ready_s[1], 1'b1);
    if (in_ready_s[1]) begin
      exp_q[1].push_back(ref_enc(kk, mm));
      acc_q[1].push_back(cyc + 1);
    end
    @(posedge clk); #1;
    in_valid_s[1] = 1'b0;
    @(negedge clk);
    check_b("b2b_busy_l1", busy_s[1], 1'b1);
    check_b("b2b_valid_drop_l1", out_valid_s[1], 1'b0);
    wait_done(1);

    // Reset in the middle of a UNROLL=1 operation, then rerun vector 1
    send(0, 80'h0, 64'h0, 64'h5579C1387B228445);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q[0].delete();
    acc_q[0].delete();
    check_b("midrst_out_valid", out_valid_s[0], 1'b0);
    check_b("midrst_busy", busy_s[0], 1'b0);
    check_w("midrst_c", c_s[0], 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_b("midrst_in_ready", in_ready_s[0], 1'b1);
    send(0, 80'h0, 64'h0, 64'h5579C1387B228445);
    wait_done(0);

    // Random traffic with a randomly stalling sink on every lane
    for (int i = 0; i < NL; i++) sink_mode[i] = 1;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NL; i++) begin
        kk = {16'($urandom), $urandom, $urandom};
        mm = {$urandom, $urandom};
        send(i, kk, mm, ref_enc(kk, mm));
      end
    end
    for (int i = 0; i < NL; i++) wait_done(i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
